// File: rtl/scp_light_sequencer_if.sv
// Control and lamp bundle between the light sequencer and its controller.
// The master modport drives the controls and the slave modport drives the lamps.
// With CYCLE_COUNT_EN defined, the bundle also carries cycle_count.
interface scp_light_sequencer_if;
    logic       enable;
    logic       hold;
    logic       force_red;
    logic       green;
    logic       yellow;
    logic       red;
    logic [5:0] timer;
    logic [2:0] phase;
    logic       phase_done;
`ifdef CYCLE_COUNT_EN
    logic [7:0] cycle_count;

    modport master (
        output enable, hold, force_red,
        input  green, yellow, red, timer, phase, phase_done, cycle_count
    );
    modport slave (
        input  enable, hold, force_red,
        output green, yellow, red, timer, phase, phase_done, cycle_count
    );
`else
    modport master (
        output enable, hold, force_red,
        input  green, yellow, red, timer, phase, phase_done
    );
    modport slave (
        input  enable, hold, force_red,
        output green, yellow, red, timer, phase, phase_done
    );
`endif
endinterface

// File: rtl/scp_light_sequencer.sv
// Phase sequencer feeding the scp_079 light monitor.
// The sequence is GREEN -> YELLOW -> RED -> CLEAR -> GREEN, and each phase lasts a fixed
// number of clocks. The sequencer supports enable, hold and a force_red early exit.
// With CYCLE_COUNT_EN defined, a saturating count of completed cycles is added.
module scp_light_sequencer #(
    parameter int unsigned GREEN_CYCLES  = 35,
    parameter int unsigned YELLOW_CYCLES = 5,
    parameter int unsigned RED_CYCLES    = 25,
    parameter int unsigned CLEAR_CYCLES  = 12
) (
    input logic                  clock,
    input logic                  reset,
    scp_light_sequencer_if.slave bus
);
    localparam logic [2:0] PH_IDLE   = 3'd0;
    localparam logic [2:0] PH_GREEN  = 3'd1;
    localparam logic [2:0] PH_YELLOW = 3'd2;
    localparam logic [2:0] PH_RED    = 3'd3;
    localparam logic [2:0] PH_CLEAR  = 3'd4;

    localparam logic [5:0] GREEN_LEN  = 6'(GREEN_CYCLES);
    localparam logic [5:0] YELLOW_LEN = 6'(YELLOW_CYCLES);
    localparam logic [5:0] RED_LEN    = 6'(RED_CYCLES);
    localparam logic [5:0] CLEAR_LEN  = 6'(CLEAR_CYCLES);

    logic [2:0] phase_q, phase_d;
    logic [5:0] timer_q, timer_d;
    logic [5:0] phase_len;
    logic       at_end;
    logic       clear_stall;

    // Length of the phase currently being timed
    always_comb begin
        phase_len = '0;
        case (phase_q)
            PH_GREEN:  phase_len = GREEN_LEN;
            PH_YELLOW: phase_len = YELLOW_LEN;
            PH_RED:    phase_len = RED_LEN;
            PH_CLEAR:  phase_len = CLEAR_LEN;
            default:   phase_len = '0;
        endcase
    end

    assign at_end      = (phase_q != PH_IDLE) && (timer_q == phase_len);
    // Holding force_red at the end of CLEAR keeps the phase saturated instead of letting it re-enter GREEN
    assign clear_stall = (phase_q == PH_CLEAR) && bus.force_red;

    // Next phase/timer; priority is enable low > hold > force_red > normal timing
    always_comb begin
        phase_d = phase_q;
        timer_d = timer_q;
        if (!bus.enable) begin
            phase_d = PH_IDLE;
            timer_d = '0;
        end else if (!bus.hold) begin
            case (phase_q)
                PH_IDLE: begin
                    phase_d = PH_GREEN;
                    timer_d = 6'd1;
                end
                PH_GREEN: begin
                    if (bus.force_red || at_end) begin
                        phase_d = PH_YELLOW;
                        timer_d = 6'd1;
                    end else begin
                        timer_d = timer_q + 6'd1;
                    end
                end
                PH_YELLOW: begin
                    if (at_end) begin
                        phase_d = PH_RED;
                        timer_d = 6'd1;
                    end else begin
                        timer_d = timer_q + 6'd1;
                    end
                end
                PH_RED: begin
                    if (at_end) begin
                        phase_d = PH_CLEAR;
                        timer_d = 6'd1;
                    end else begin
                        timer_d = timer_q + 6'd1;
                    end
                end
                PH_CLEAR: begin
                    if (!at_end) begin
                        timer_d = timer_q + 6'd1;
                    end else if (!clear_stall) begin
                        phase_d = PH_GREEN;
                        timer_d = 6'd1;
                    end
                end
                default: begin
                    phase_d = PH_IDLE;
                    timer_d = '0;
                end
            endcase
        end
    end

    // Phase and timer registers
    always_ff @(posedge clock) begin
        if (reset) begin
            phase_q <= PH_IDLE;
            timer_q <= '0;
        end else begin
            phase_q <= phase_d;
            timer_q <= timer_d;
        end
    end

`ifdef CYCLE_COUNT_EN
    logic [7:0] cycle_count_q, cycle_count_d;

    // Count CLEAR -> GREEN wraps, saturating at 255
    always_comb begin
        cycle_count_d = cycle_count_q;
        if ((phase_q == PH_CLEAR) && (phase_d == PH_GREEN) && (cycle_count_q != '1)) begin
            cycle_count_d = cycle_count_q + 8'd1;
        end
    end

    // Cycle counter register; only reset clears it
    always_ff @(posedge clock) begin
        if (reset) begin
            cycle_count_q <= '0;
        end else begin
            cycle_count_q <= cycle_count_d;
        end
    end

    assign bus.cycle_count = cycle_count_q;
`endif

    // Lamp decode; unused phase codes show red so exactly one lamp is always lit
    always_comb begin
        bus.green  = 1'b0;
        bus.yellow = 1'b0;
        bus.red    = 1'b0;
        case (phase_q)
            PH_GREEN:  bus.green  = 1'b1;
            PH_YELLOW: bus.yellow = 1'b1;
            default:   bus.red    = 1'b1;
        endcase
    end

    assign bus.timer      = timer_q;
    assign bus.phase      = phase_q;
    assign bus.phase_done = at_end && bus.enable && !bus.hold && !clear_stall;
endmodule

// File: tb/tb_scp_light_sequencer.sv
// Scoreboard bench for scp_light_sequencer with default phase lengths 35/5/25/12.
// Each stimulus cycle pushes the state expected during that cycle, and a monitor on the falling edge pops and compares it.
module tb_scp_light_sequencer;
    localparam logic [2:0] P_IDLE = 3'd0, P_G = 3'd1, P_Y = 3'd2, P_R = 3'd3, P_C = 3'd4;

    typedef struct {
        logic [2:0] phase;
        logic [5:0] timer;
        logic       done;
        logic [7:0] cc;
    } exp_t;

    logic clock;
    logic reset;
    exp_t exp_q[$];
    int   n_checks;
    int   n_fail;
    logic [7:0] cc_exp;

    scp_light_sequencer_if bus_if ();

    scp_light_sequencer dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if)
    );

`ifdef CYCLE_COUNT_EN
    scp_light_sequencer_if bus2_if ();

    scp_light_sequencer #(
        .GREEN_CYCLES  (1),
        .YELLOW_CYCLES (1),
        .RED_CYCLES    (1),
        .CLEAR_CYCLES  (1)
    ) dut_short (
        .clock (clock),
        .reset (reset),
        .bus   (bus2_if)
    );
`endif

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, end of test not reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
        end
    endtask

    // Monitor: compare each cycle's outputs with the queued expectation
    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("phase", int'(bus_if.phase), int'(e.phase));
            chk("timer", int'(bus_if.timer), int'(e.timer));
            chk("phase_done", int'(bus_if.phase_done), int'(e.done));
            chk("green", int'(bus_if.green), int'(e.phase == P_G));
            chk("yellow", int'(bus_if.yellow), int'(e.phase == P_Y));
            chk("red", int'(bus_if.red), int'(e.phase == P_IDLE || e.phase == P_R || e.phase == P_C));
`ifdef CYCLE_COUNT_EN
            chk("cycle_count", int'(bus_if.cycle_count), int'(e.cc));
`endif
        end
    end

    // Drive one cycle of inputs, queue the expected state for that cycle, then advance past the edge
    task automatic step(input logic rs, input logic en, input logic hd, input logic fr,
                        input logic [2:0] ep, input logic [5:0] et, input logic ed);
        exp_t e;
        reset = rs;
        bus_if.enable = en;
        bus_if.hold = hd;
        bus_if.force_red = fr;
        e.phase = ep;
        e.timer = et;
        e.done = ed;
        e.cc = cc_exp;
        exp_q.push_back(e);
        @(posedge clock);
        #1;
    endtask

    // Free-running cycles inside one phase, timer first..last, done on timer==len
    task automatic run_phase(input logic [2:0] p, input int first, input int last, input int len);
        for (int t = first; t <= last; t++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, p, 6'(t), logic'(t == len));
        end
    endtask

    task automatic run_cycle();
        run_phase(P_G, 1, 35, 35);
        run_phase(P_Y, 1, 5, 5);
        run_phase(P_R, 1, 25, 25);
        run_phase(P_C, 1, 12, 12);
        cc_exp++;
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        cc_exp = '0;
        reset = 1'b1;
        bus_if.enable = 1'b0;
        bus_if.hold = 1'b0;
        bus_if.force_red = 1'b0;
`ifdef CYCLE_COUNT_EN
        bus2_if.enable = 1'b0;
        bus2_if.hold = 1'b0;
        bus2_if.force_red = 1'b0;
`endif
        @(posedge clock);
        #1;

        // Reset state, idle while disabled, then one full cycle (GREEN timer=1 again at edge 78)
        step(1'b0, 1'b0, 1'b0, 1'b0, P_IDLE, 6'd0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, P_IDLE, 6'd0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, P_IDLE, 6'd0, 1'b0);
        run_cycle();

        // force_red is ignored under hold, then taken at GREEN timer=10 and ignored in YELLOW
        run_phase(P_G, 1, 4, 35);
        step(1'b0, 1'b1, 1'b1, 1'b1, P_G, 6'd5, 1'b0);
        run_phase(P_G, 5, 9, 35);
        step(1'b0, 1'b1, 1'b0, 1'b1, P_G, 6'd10, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, P_Y, 6'd1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1, P_Y, 6'd2, 1'b0);
        run_phase(P_Y, 3, 5, 5);

        // hold for 7 clocks at RED timer=12, then RED finishes 13 clocks later
        run_phase(P_R, 1, 11, 25);
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0, P_R, 6'd12, 1'b0);
        end
        run_phase(P_R, 12, 25, 25);

        // force_red held at the end of CLEAR saturates the phase until it drops
        run_phase(P_C, 1, 11, 12);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b1, P_C, 6'd12, 1'b0);
        end
        step(1'b0, 1'b1, 1'b0, 1'b0, P_C, 6'd12, 1'b1);
        cc_exp++;

        // enable low at YELLOW timer=3, enable low overriding hold, then reset mid-GREEN
        run_phase(P_G, 1, 35, 35);
        run_phase(P_Y, 1, 2, 5);
        step(1'b0, 1'b0, 1'b0, 1'b0, P_Y, 6'd3, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, P_IDLE, 6'd0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, P_IDLE, 6'd0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, P_G, 6'd1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, P_IDLE, 6'd0, 1'b0);
        run_phase(P_G, 1, 5, 35);
        step(1'b1, 1'b1, 1'b0, 1'b0, P_G, 6'd6, 1'b0);
        cc_exp = '0;
        step(1'b0, 1'b1, 1'b0, 1'b0, P_IDLE, 6'd0, 1'b0);

        // Three uninterrupted cycles after reset
        run_cycle();
        run_cycle();
        run_cycle();
        step(1'b0, 1'b1, 1'b0, 1'b0, P_G, 6'd1, 1'b0);

`ifdef CYCLE_COUNT_EN
        // All-length-1 instance: one wrap every 4 edges, so 1210 edges exceeds 255 wraps
        bus2_if.enable = 1'b1;
        repeat (1210) @(posedge clock);
        @(negedge clock);
        chk("short_cycle_count_sat", int'(bus2_if.cycle_count), 255);
`endif

        repeat (3) @(negedge clock);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
